// File: rtl/uart_frame_rx.sv
// uart_frame_rx: deframes SOF/LEN/payload/CHK byte streams and releases checked payloads
//
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   in_data    received byte            (in_valid / in_ready handshake)
//   out_data   payload byte             (out_valid / out_ready handshake)
//   out_last   marks the final payload byte of a frame
//   frame_ok   one-cycle pulse when a frame passes its checksum
//   frame_err  one-cycle pulse when a frame is dropped
//
// Optional feature: define UART_FRAME_TIMEOUT_EN to abort a frame that stalls
// for TIMEOUT cycles between bytes in LEN, PAYLOAD or CHK.
module uart_frame_rx #(
    parameter int         MAX_LEN = 16,
    parameter logic [7:0] SOF     = 8'h55,
    parameter int         TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err
);
    localparam int IW = $clog2(MAX_LEN + 1);
    // Buffer address width; indices never reach MAX_LEN when used as addresses.
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX8 = 8'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, DRAIN} state_t;

    state_t        state, state_nx;
    logic [7:0]    mem [1 << AW];
    logic [IW-1:0] len, wr_idx, rd_idx;
    logic [7:0]    chk;
    logic          acc, ox, to, ok_nx, err_nx, len_ok, last_pl;

    assign in_ready = state != DRAIN;
    assign acc      = in_valid && in_ready;
    assign ox       = out_valid && out_ready;
    assign len_ok   = (in_data != 8'd0) && (in_data <= MAX8);
    assign last_pl  = (wr_idx + IW'(1)) == len;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    logic          active;
    assign active = (state == LEN) || (state == PAYLOAD) || (state == CHK);
    // An accepted byte always beats an expiring counter.
    assign to = active && !acc && (tcnt == TW'(TIMEOUT - 1));
    always_ff @(posedge clk) begin
        if (!rst || !active || acc || state_nx != state)
            tcnt <= '0;
        else
            tcnt <= tcnt + TW'(1);
    end
`else
    // Without the feature a stalled frame waits forever; TIMEOUT has no effect.
    assign to = TIMEOUT < 0;
`endif

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ok_nx    = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (acc && in_data == SOF)
                    state_nx = LEN;
            end
            LEN: begin
                if (acc) begin
                    state_nx = len_ok ? PAYLOAD : IDLE;
                    err_nx   = !len_ok;
                end else if (to) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end
            end
            PAYLOAD: begin
                if (acc && last_pl) begin
                    state_nx = CHK;
                end else if (to) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end
            end
            CHK: begin
                if (acc) begin
                    ok_nx    = in_data == chk;
                    err_nx   = in_data != chk;
                    state_nx = (in_data == chk) ? DRAIN : IDLE;
                end else if (to) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end
            end
            DRAIN: begin
                if (ox && out_last)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Payload storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (state == PAYLOAD && acc)
            mem[wr_idx[AW-1:0]] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            len       <= '0;
            chk       <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_ok  <= ok_nx;
            frame_err <= err_nx;
            case (state)
                IDLE: begin
                    if (acc && in_data == SOF) begin
                        wr_idx <= '0;
                        rd_idx <= '0;
                    end
                end
                LEN: begin
                    if (acc && len_ok) begin
                        len <= in_data[IW-1:0];
                        chk <= in_data;
                    end
                end
                PAYLOAD: begin
                    if (acc) begin
                        wr_idx <= wr_idx + IW'(1);
                        chk    <= chk ^ in_data;
                    end
                end
                CHK: begin
                    // First byte is presented the cycle after the checksum is accepted.
                    if (acc && in_data == chk) begin
                        out_valid <= 1'b1;
                        out_data  <= mem[0];
                        out_last  <= len == IW'(1);
                        rd_idx    <= IW'(1);
                    end
                end
                DRAIN: begin
                    if (ox) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            out_data <= mem[rd_idx[AW-1:0]];
                            out_last <= rd_idx == len - IW'(1);
                            rd_idx   <= rd_idx + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
